// File: rtl/nbout_psum_ctrl.sv
// NBout partial-sum buffer and group sequencer beside NFU-2: issues output-neuron groups across
// input passes, feeds back stored partial sums aligned with the final tree stage, and forwards last-pass results.

module nbout_lane #(
  parameter int N  = 16,
  parameter int GW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [GW-1:0] addr,
  input  logic [N-1:0]  wdata,
  input  logic          zero,
  output logic [N-1:0]  rdata
);
  logic [N-1:0] mem [2**GW];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // zero is the identity for both sum and unsigned max, so pass 0 never sees stale contents
  assign rdata = zero ? '0 : mem[addr];
endmodule

module nbout_psum_ctrl #(
  parameter int N   = 16,
  parameter int Tn  = 16,
  parameter int GW  = 6,
  parameter int PW  = 8,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [GW:0]     i_num_groups,
  input  logic [PW-1:0]   i_num_passes,
  input  logic            i_op,
  input  logic            i_stall,
  output logic            o_busy,
  output logic            o_op,
  output logic            o_issue,
  output logic [GW-1:0]   o_issue_group,
  output logic [N*Tn-1:0] o_nbout,
  input  logic [N*Tn-1:0] i_nfu2_out,
  output logic            o_out_valid,
  output logic [GW-1:0]   o_out_group,
  output logic [N*Tn-1:0] o_out_data,
  output logic            o_done
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [GW-1:0] grp;
    logic          first;
    logic          last;
  } dl_t;

  state_t        state;
  logic [GW:0]   groups_q;
  logic [PW-1:0] passes_q;
  logic [GW-1:0] g_q;
  logic [PW-1:0] p_q;
  logic          busy_q, done_q, op_q;
  logic          g_last, p_last;

  logic [LAT:1]  vld_pipe;
  dl_t  [LAT:1]  dl_pipe;
  logic          d_vld;
  dl_t           d;

  logic [Tn-1:0][N-1:0] nb_lanes, res_lanes;

  assign g_last = ({1'b0, g_q} == groups_q - (GW+1)'(1));
  assign p_last = (p_q == passes_q - PW'(1));

  assign o_issue       = (state == S_ISSUE) && !i_stall;
  assign o_issue_group = g_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_op          = op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      op_q     <= 1'b0;
      groups_q <= '0;
      passes_q <= '0;
      g_q      <= '0;
      p_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          op_q     <= i_op;
          groups_q <= i_num_groups;
          passes_q <= i_num_passes;
          g_q      <= '0;
          p_q      <= '0;
          if (i_num_groups == '0 || i_num_passes == '0) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            state  <= S_ISSUE;
            busy_q <= 1'b1;
          end
        end
        S_ISSUE: if (!i_stall) begin
          if (g_last) begin
            g_q <= '0;
            if (p_last) state <= S_DRAIN;
            else        p_q   <= p_q + PW'(1);
          end else begin
            g_q <= g_q + GW'(1);
          end
        end
        S_DRAIN: if (!(|vld_pipe)) begin
          state  <= S_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // free-running: stalls only stop new issues, in-flight groups still write back
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dl_pipe  <= '0;
    end else begin
      for (int s = LAT; s > 1; s--) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dl_pipe[s]  <= dl_pipe[s-1];
      end
      vld_pipe[1] <= o_issue;
      dl_pipe[1]  <= '{grp: g_q, first: (p_q == '0), last: p_last};
    end
  end

  assign d_vld     = vld_pipe[LAT];
  assign d         = dl_pipe[LAT];
  assign res_lanes = i_nfu2_out;
  assign o_nbout   = nb_lanes;

  for (genvar l = 0; l < Tn; l++) begin : g_lane
    nbout_lane #(.N(N), .GW(GW)) u_lane (
      .clk   (clk),
      .we    (d_vld && !rst),
      .addr  (d.grp),
      .wdata (res_lanes[l]),
      .zero  (!d_vld || d.first),
      .rdata (nb_lanes[l])
    );
  end

  assign o_out_valid = d_vld && d.last;
  assign o_out_group = o_out_valid ? d.grp : '0;
  assign o_out_data  = o_out_valid ? i_nfu2_out : '0;
endmodule

// File: tb/tb_nbout_psum_ctrl.sv
// Bench for nbout_psum_ctrl: NFU-2 behavioural model closes the loop, scoreboard queues hold expected psums/results.
module tb_nbout_psum_ctrl;
  localparam int N = 16, TN = 16, GW = 6, PW = 8, W = N*TN;

  logic clk = 1'b0;
  logic rst, i_start, i_op, i_stall;
  logic [GW:0] i_num_groups;
  logic [PW-1:0] i_num_passes;
  logic o_busy, o_op, o_issue, o_out_valid, o_done;
  logic [GW-1:0] o_issue_group, o_out_group;
  logic [W-1:0] o_nbout, i_nfu2_out, o_out_data;

  always #5 clk = ~clk;

  nbout_psum_ctrl #(.N(N), .Tn(TN), .GW(GW), .PW(PW), .LAT(1)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_groups(i_num_groups),
    .i_num_passes(i_num_passes), .i_op(i_op), .i_stall(i_stall), .o_busy(o_busy),
    .o_op(o_op), .o_issue(o_issue), .o_issue_group(o_issue_group), .o_nbout(o_nbout),
    .i_nfu2_out(i_nfu2_out), .o_out_valid(o_out_valid), .o_out_group(o_out_group),
    .o_out_data(o_out_data), .o_done(o_done)
  );

  typedef struct { logic [GW-1:0] grp; logic [W-1:0] data; } out_t;

  logic [W-1:0] nbq[$];
  out_t outq[$];
  int total = 0, bad = 0;
  int cyc = 0, n_issue = 0, out_cnt = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0;
  int stall_left = 0, stall_after = 0;
  int j_groups = 1, j_passes = 1, j_mode = 0, j_cval = 0;
  bit j_op = 1'b0;
  logic [W-1:0] acc [64];
  logic [W-1:0] cur_vec = '0, pend_vec = '0;
  logic pend_v = 1'b0, pend_op = 1'b0;
  int pass_val [3] = '{3, 9, 4};

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] nfu2(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [N-1:0] x, y;
    for (int l = 0; l < TN; l++) begin
      x = a[l*N +: N];
      y = b[l*N +: N];
      r[l*N +: N] = op ? ((x > y) ? x : y) : x + y;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] splat(input int v);
    logic [W-1:0] r;
    for (int l = 0; l < TN; l++) r[l*N +: N] = N'(v);
    return r;
  endfunction

  // NFU-2 model: final-stage combine of the stored psum with the data issued one cycle earlier
  always_comb i_nfu2_out = pend_v ? nfu2(pend_op, o_nbout, pend_vec) : '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    pend_v   <= o_issue && !rst;
    pend_vec <= cur_vec;
    pend_op  <= o_op;
  end

  always @(posedge clk) begin
    #1;
    i_stall = (stall_left > 0);
    if (stall_left > 0) stall_left--;
  end

  always @(negedge clk) begin
    int gi, ps;
    logic [W-1:0] vec, prev;
    out_t r;
    if (!rst) begin
      if (pend_v) begin
        if (nbq.size() == 0) chk("nb_underflow", 0, 1);
        else chk("nbout", o_nbout, nbq.pop_front());
      end
      if (o_out_valid) begin
        out_cnt++;
        if (outq.size() == 0) chk("out_underflow", 0, 1);
        else begin
          r = outq.pop_front();
          chk("out_grp", o_out_group, r.grp);
          chk("out_data", o_out_data, r.data);
        end
      end
      if (o_done) begin
        done_cnt++;
        chk("done_busy", o_busy, 0);
      end
      if (o_issue) begin
        gi = n_issue % j_groups;
        ps = n_issue / j_groups;
        chk("iss_grp", o_issue_group, gi);
        chk("iss_op", o_op, j_op);
        chk("iss_busy", o_busy, 1);
        case (j_mode)
          0: vec = splat(j_cval);
          1: vec = splat(pass_val[ps % 3]);
          default: for (int l = 0; l < TN; l++) vec[l*N +: N] = N'($urandom);
        endcase
        prev = (ps == 0) ? '0 : acc[gi];
        nbq.push_back(prev);
        acc[gi] = nfu2(j_op, prev, vec);
        if (ps == j_passes - 1) begin
          r.grp  = GW'(gi);
          r.data = acc[gi];
          outq.push_back(r);
        end
        cur_vec = vec;
        if (n_issue == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_issue++;
        if (n_issue == stall_after) stall_left = 3;
      end
    end
  end

  task automatic setup(input int g, input int p, input bit op, input int mode, input int cval, input int st);
    j_groups = g; j_passes = p; j_op = op; j_mode = mode; j_cval = cval;
    n_issue = 0; out_cnt = 0; done_cnt = 0; first_cyc = 0; last_cyc = 0; stall_after = st;
    nbq.delete(); outq.delete();
    @(negedge clk); #1;
    i_start = 1'b1; i_num_groups = (GW+1)'(g); i_num_passes = PW'(p); i_op = op;
    @(negedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run_job(input string tag, input int g, input int p, input bit op, input int mode,
                         input int cval, input int st, input bit ig);
    int expn, span, budget;
    setup(g, p, op, mode, cval, st);
    chk({tag, "_busy"}, o_busy, 1);
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      if (ig && budget == 2) begin
        i_start = 1'b1; i_num_groups = 5; i_num_passes = 1; i_op = ~op;
      end else i_start = 1'b0;
      @(negedge clk); #1;
      budget++;
    end
    i_start = 1'b0;
    if (budget >= 3000) chk({tag, "_timeout"}, 0, 1);
    expn = g * p;
    span = expn - 1 + ((st > 0 && st < expn) ? 3 : 0);
    chk({tag, "_issues"}, n_issue, expn);
    chk({tag, "_span"}, last_cyc - first_cyc, span);
    chk({tag, "_outs"}, out_cnt, g);
    chk({tag, "_q_left"}, nbq.size() + outq.size(), 0);
    @(negedge clk); #1;
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle_busy"}, o_busy, 0);
    chk({tag, "_idle_issue"}, o_issue, 0);
  endtask

  initial begin
    int oc, dc, budget, g, p;
    rst = 1'b1; i_start = 1'b0; i_op = 1'b0; i_stall = 1'b0;
    i_num_groups = '0; i_num_passes = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_issue", o_issue, 0);
    chk("rst_outv", o_out_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_op", o_op, 0);
    chk("rst_igrp", o_issue_group, 0);
    chk("rst_ogrp", o_out_group, 0);
    chk("rst_nbout", o_nbout, 0);
    #1 rst = 1'b0;

    run_job("t1", 2, 3, 1'b0, 0, 5, 0, 1'b0);
    run_job("t2", 1, 4, 1'b0, 0, 7, 0, 1'b1);
    run_job("t3", 3, 3, 1'b1, 1, 0, 0, 1'b0);
    run_job("t4", 2, 3, 1'b0, 0, 5, 2, 1'b0);

    setup(2, 3, 1'b0, 0, 5, 0);
    budget = 0;
    while (n_issue < 3 && budget < 100) begin
      @(negedge clk); #1;
      budget++;
    end
    if (budget >= 100) chk("t5_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("t5_busy", o_busy, 0);
    chk("t5_issue", o_issue, 0);
    chk("t5_igrp", o_issue_group, 0);
    nbq.delete(); outq.delete();
    oc = out_cnt; dc = done_cnt;
    repeat (8) @(negedge clk);
    #1;
    chk("t5_no_out", out_cnt, oc);
    chk("t5_no_done", done_cnt, dc);
    run_job("t5b", 2, 3, 1'b0, 0, 5, 0, 1'b0);

    setup(2, 0, 1'b1, 0, 0, 0);
    chk("t6_done", o_done, 1);
    chk("t6_busy", o_busy, 0);
    @(negedge clk); #1;
    chk("t6_done_off", o_done, 0);
    setup(0, 3, 1'b0, 0, 0, 0);
    chk("t6b_done", o_done, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("t6_issues", n_issue, 0);
    chk("t6_done_cnt", done_cnt, 1);

    for (int k = 0; k < 4; k++) begin
      g = $urandom_range(1, 6);
      p = $urandom_range(1, 4);
      run_job("rnd", g, p, 1'($urandom_range(0, 1)), 2, 0, $urandom_range(0, g*p), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "global timeout");
  end
endmodule
